pipe_exc_ctrl: RTL and testbench
================================

PIPE_EXC_CTRL -- requirements
Module: pipe_exc_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles of a multiply.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles of a divide (4-bit counter; both parameters SHALL be 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 load_use_D  input  1  load-use hazard detected for the instruction in D.
REQ-006 md_use_D  input  1  instruction in D is mult/div or reads/writes HI/LO.
REQ-007 md_start_E  input  1  mult/div instruction in E this cycle.
REQ-008 md_is_div_E  input  1  1 = divide, 0 = multiply (valid with md_start_E).
REQ-009 overflow_M  input  1  pipelined overflow flag of the instruction in M.
REQ-010 eret_M  input  1  eret instruction in M.
REQ-011 en_pc, en_FD, en_DE, en_EM, en_MW  output  1 each  write enables of PC and pipeline registers (including the overflow flag stages).
REQ-012 flush_DE  output  1  load bubble into D/E register.
REQ-013 flush_all  output  1  clear F/D, D/E, E/M registers.
REQ-014 exc_pc_sel, eret_pc_sel  output  1 each  PC mux select: handler vector / EPC.
REQ-015 md_busy  output  1  mult/div unit busy; in_handler  output  1  FSM in HANDLER; double_fault  output  1  sticky.

Function
REQ-016 Registered state SHALL be: FSM {RUN, HANDLER}, 4-bit md counter, double_fault; all other outputs combinational (Mealy) from state and inputs.
REQ-017 md_busy SHALL equal (counter != 0); counter decrements by 1 per cycle while nonzero.
REQ-018 md_start_E with counter 0 and flush_all 0 SHALL load DIV_CYCLES if md_is_div_E else MULT_CYCLES; md_busy rises the next cycle and stays high exactly N cycles.
REQ-019 md_start_E while counter != 0 SHALL be ignored (no reload).
REQ-020 stall SHALL be load_use_D | (md_use_D & (md_busy | md_start_E)).
REQ-021 Stall with no flush: en_pc=en_FD=0, flush_DE=1, en_DE=en_EM=en_MW=1.
REQ-022 No stall, no flush: all en_* = 1, flush_DE=0, flush_all=0.
REQ-023 RUN and overflow_M=1: same cycle flush_all=1, exc_pc_sel=1, all en_*=1, flush_DE=0 (exception overrides stall); next state HANDLER.
REQ-024 HANDLER and eret_M=1: same cycle flush_all=1, eret_pc_sel=1, all en_*=1; next state RUN.
REQ-025 HANDLER and overflow_M=1 with eret_M=0: no flush, no PC select; double_fault set next cycle, held until reset.
REQ-026 HANDLER with overflow_M and eret_M both 1: treated as eret only; double_fault unchanged.
REQ-027 eret_M in RUN SHALL be ignored (no flush, no state change).
REQ-028 md_start_E in a flush_all cycle SHALL be ignored (younger instruction); an already-running counter continues decrementing through flushes.
REQ-029 exc_pc_sel and eret_pc_sel SHALL never be high together; in_handler = (state == HANDLER).

Reset
REQ-030 reset=0 at a rising edge SHALL set state RUN, counter 0, double_fault 0.
REQ-031 While reset=0: all en_*=0, flush_DE=0, flush_all=0, exc_pc_sel=0, eret_pc_sel=0, regardless of other inputs.
REQ-032 Reset mid-operation (counter nonzero or HANDLER) SHALL abort it; first cycle after release behaves as REQ-022 given idle inputs.

Verification
REQ-033 load_use_D=1 one cycle -> that cycle en_pc=en_FD=0, flush_DE=1; next cycle all en_*=1.
REQ-034 md_start_E=1, md_is_div_E=1, then md_use_D=1 held -> md_busy high 10 cycles, stall asserted during md_start_E cycle plus 10 busy cycles, released after.
REQ-035 RUN, overflow_M=1 with load_use_D=1 -> flush_all=1, exc_pc_sel=1, en_pc=1, flush_DE=0; in_handler=1 next cycle.
REQ-036 HANDLER, overflow_M=1 -> no flush, double_fault=1 next cycle; then eret_M=1 -> flush_all=1, eret_pc_sel=1, RUN next cycle, double_fault stays 1.
REQ-037 Mult started (counter 5), overflow_M=1 two cycles later with md_start_E=1 -> counter not reloaded, md_busy falls exactly 5 cycles after first start.
REQ-038 reset=0 in HANDLER with counter 7 -> after release in_handler=0, md_busy=0, double_fault=0, all en_*=1.

Source files
------------

// File: rtl/pipe_exc_ctrl.sv
// Pipeline hazard and exception controller: load-use / mult-div stalls,
// overflow exception entry, eret return and a sticky double-fault flag.
module pipe_exc_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic load_use_D,
   input  logic md_use_D,
   input  logic md_start_E,
   input  logic md_is_div_E,
   input  logic overflow_M,
   input  logic eret_M,
   output logic en_pc,
   output logic en_FD,
   output logic en_DE,
   output logic en_EM,
   output logic en_MW,
   output logic flush_DE,
   output logic flush_all,
   output logic exc_pc_sel,
   output logic eret_pc_sel,
   output logic md_busy,
   output logic in_handler,
   output logic double_fault
);

   typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       dfault_q, dfault_d;

   logic stall, take_exc, take_eret;

   always_comb begin
      // Every control action is gated by reset so the pipeline freezes cleanly.
      take_exc  = reset && (state_q == RUN) && overflow_M;
      take_eret = reset && (state_q == HANDLER) && eret_M;
      md_busy   = (cnt_q != 4'd0);
      stall     = load_use_D | (md_use_D & (md_busy | md_start_E));

      flush_all   = take_exc | take_eret;
      exc_pc_sel  = take_exc;
      eret_pc_sel = take_eret;
      en_pc       = reset & (flush_all | ~stall);
      en_FD       = reset & (flush_all | ~stall);
      en_DE       = reset;
      en_EM       = reset;
      en_MW       = reset;
      flush_DE    = reset & ~flush_all & stall;

      in_handler   = (state_q == HANDLER);
      double_fault = dfault_q;

      state_d = state_q;
      if (take_exc)
         state_d = HANDLER;
      else if (take_eret)
         state_d = RUN;

      // Overflow inside the handler with eret present is treated as eret only.
      dfault_d = dfault_q | ((state_q == HANDLER) & overflow_M & ~eret_M);

      cnt_d = cnt_q;
      if (md_busy)
         cnt_d = cnt_q - 4'd1;
      else if (md_start_E && !flush_all)
         cnt_d = md_is_div_E ? DIV_N : MULT_N;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= RUN;
         cnt_q    <= 4'd0;
         dfault_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dfault_q <= dfault_d;
      end
   end

endmodule

// File: tb/tb_pipe_exc_ctrl.sv
// Directed bench for pipe_exc_ctrl: hand-computed control vectors checked
// with immediate assertions, one directed step after another.
module tb_pipe_exc_ctrl;

   logic clk = 1'b0;
   logic reset, load_use_D, md_use_D, md_start_E, md_is_div_E, overflow_M, eret_M;
   logic en_pc, en_FD, en_DE, en_EM, en_MW, flush_DE, flush_all;
   logic exc_pc_sel, eret_pc_sel, md_busy, in_handler, double_fault;

   int vectors = 0;
   int miscompares = 0;

   // {en_pc,en_FD,en_DE,en_EM,en_MW,flush_DE,flush_all,exc_pc_sel,eret_pc_sel}
   localparam logic [8:0] C_RST  = 9'b00000_0000;
   localparam logic [8:0] C_RUN  = 9'b11111_0000;
   localparam logic [8:0] C_STL  = 9'b00111_1000;
   localparam logic [8:0] C_EXC  = 9'b11111_0110;
   localparam logic [8:0] C_ERET = 9'b11111_0101;

   logic [8:0] ctl;
   logic [2:0] st;  // {md_busy,in_handler,double_fault}
   assign ctl = {en_pc, en_FD, en_DE, en_EM, en_MW, flush_DE, flush_all, exc_pc_sel, eret_pc_sel};
   assign st  = {md_busy, in_handler, double_fault};

   always #5 clk = ~clk;

   pipe_exc_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .load_use_D(load_use_D), .md_use_D(md_use_D), .md_start_E(md_start_E),
      .md_is_div_E(md_is_div_E), .overflow_M(overflow_M), .eret_M(eret_M),
      .en_pc(en_pc), .en_FD(en_FD), .en_DE(en_DE), .en_EM(en_EM), .en_MW(en_MW),
      .flush_DE(flush_DE), .flush_all(flush_all),
      .exc_pc_sel(exc_pc_sel), .eret_pc_sel(eret_pc_sel),
      .md_busy(md_busy), .in_handler(in_handler), .double_fault(double_fault)
   );

   task automatic chk_ctl(input string tag, input logic [8:0] exp);
      vectors++;
      assert (ctl === exp) else begin
         miscompares++;
         $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp);
      end
      $display("vec %0d %s ctl=%b", vectors, tag, ctl);
   endtask

   task automatic chk_st(input string tag, input logic [2:0] exp);
      vectors++;
      assert (st === exp) else begin
         miscompares++;
         $error("FAIL %s busy/hnd/df observed=%b expected=%b", tag, st, exp);
      end
      $display("vec %0d %s busy/hnd/df=%b", vectors, tag, st);
   endtask

   // Advance to just after the next rising edge; inputs are driven there
   // and outputs sampled 1 time unit later.
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      load_use_D = 0; md_use_D = 0; md_start_E = 0;
      md_is_div_E = 0; overflow_M = 0; eret_M = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 0;
      cyc(); cyc();
      load_use_D = 1; overflow_M = 1; eret_M = 1; md_start_E = 1; #1;
      chk_ctl("reset_ctl", C_RST);
      chk_st("reset_state", 3'b000);
      cyc();
      idle(); reset = 1; #1;
      chk_ctl("after_reset_ctl", C_RUN);
      chk_st("after_reset_state", 3'b000);

      // Load-use stall for one cycle.
      cyc(); load_use_D = 1; #1;
      chk_ctl("load_use_stall", C_STL);
      cyc(); load_use_D = 0; #1;
      chk_ctl("load_use_release", C_RUN);

      // Divide with dependent instruction held in D.
      cyc(); md_start_E = 1; md_is_div_E = 1; md_use_D = 1; #1;
      chk_ctl("div_start_stall", C_STL);
      chk_st("div_start_notbusy", 3'b000);
      for (int i = 1; i <= 10; i++) begin
         cyc(); md_start_E = 0; md_is_div_E = 0; #1;
         chk_ctl($sformatf("div_busy_stall_%0d", i), C_STL);
         chk_st($sformatf("div_busy_%0d", i), 3'b100);
      end
      cyc(); #1;
      chk_ctl("div_done_release", C_RUN);
      chk_st("div_done_idle", 3'b000);
      md_use_D = 0;

      // Multiply, then overflow with a second start two cycles later.
      cyc(); md_start_E = 1; #1;
      chk_ctl("mul_start", C_RUN);
      cyc(); md_start_E = 0; #1;
      chk_st("mul_busy_cnt5", 3'b100);
      cyc(); overflow_M = 1; md_start_E = 1; #1;
      chk_ctl("ovf_exc_during_mul", C_EXC);
      cyc(); overflow_M = 0; md_start_E = 0; #1;
      chk_st("handler_cnt3", 3'b110);
      cyc(); cyc(); #1;
      chk_st("handler_cnt1", 3'b110);
      cyc(); #1;
      chk_st("mul_fall_5_cycles", 3'b010);

      // Overflow in handler -> double fault, then eret.
      overflow_M = 1; #1;
      chk_ctl("handler_ovf_noflush", C_RUN);
      cyc(); overflow_M = 0; #1;
      chk_st("double_fault_set", 3'b011);
      eret_M = 1; #1;
      chk_ctl("eret_flush", C_ERET);
      cyc(); #1;
      chk_ctl("eret_in_run_ignored", C_RUN);
      chk_st("back_in_run_df_held", 3'b001);
      cyc(); eret_M = 0; #1;
      chk_st("eret_run_no_state_change", 3'b001);

      // Exception cycle swallows a start from a younger instruction.
      overflow_M = 1; md_start_E = 1; #1;
      chk_ctl("exc_with_start", C_EXC);
      cyc(); md_start_E = 0; #1;
      chk_st("start_ignored_in_flush", 3'b011);

      // Overflow and eret together in handler: eret only.
      eret_M = 1; #1;
      chk_ctl("ovf_eret_is_eret", C_ERET);
      cyc(); eret_M = 0; overflow_M = 0; #1;
      chk_st("ovf_eret_state", 3'b001);

      // Exception overrides load-use stall.
      overflow_M = 1; load_use_D = 1; #1;
      chk_ctl("exc_over_stall", C_EXC);
      cyc(); overflow_M = 0; load_use_D = 0; #1;
      chk_st("exc_enter_handler", 3'b011);

      // Reset in handler with divide counter at 7.
      md_start_E = 1; md_is_div_E = 1;
      cyc(); md_start_E = 0; md_is_div_E = 0;
      cyc(); cyc(); cyc(); #1;
      chk_st("handler_cnt7", 3'b111);
      reset = 0; load_use_D = 1; #1;
      chk_ctl("reset_midop_ctl", C_RST);
      cyc(); reset = 1; load_use_D = 0; #1;
      chk_ctl("post_reset_ctl", C_RUN);
      chk_st("post_reset_state", 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
